// File: rtl/qpc_hdr_table.sv
// rtl/qpc_hdr_table.sv - per-QP header context store with PSN/MSN write-back and per-QP lookup lock
module qpc_hdr_table #(
  parameter int MAX_QP             = 32,
  parameter int QP_PTR_WIDTH       = 5,
  parameter int ETH_MAC_WIDTH      = 48,
  parameter int IPV6_WIDTH         = 128,
  parameter int IB_PKEY_WIDTH      = 16,
  parameter int IB_PMTU_CODE_WIDTH = 3,
  parameter int IB_QP_WIDTH        = 24,
  parameter int IP_TTL_WIDTH       = 8,
  parameter int IP_DSCP_WDITH      = 6,
  parameter int IB_PSN_WIDTH       = 24,
  parameter int IB_MSN_WIDTH       = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_cfg_wr_en,
  input  logic [QP_PTR_WIDTH-1:0]       i_cfg_qpid,
  input  logic [IB_PKEY_WIDTH-1:0]      i_cfg_pkey,
  input  logic [IB_PMTU_CODE_WIDTH-1:0] i_cfg_pmtu,
  input  logic [IB_QP_WIDTH-1:0]        i_cfg_dest_qpid,
  input  logic [IPV6_WIDTH-1:0]         i_cfg_dest_ip,
  input  logic [IP_TTL_WIDTH-1:0]       i_cfg_ttl,
  input  logic [IP_DSCP_WDITH-1:0]      i_cfg_dscp,
  input  logic [ETH_MAC_WIDTH-1:0]      i_cfg_dest_mac,
  input  logic [IB_PSN_WIDTH-1:0]       i_cfg_init_psn,
  input  logic [IB_MSN_WIDTH-1:0]       i_cfg_init_msn,
  input  logic                          i_qpc_hdr_lookup_valid,
  output logic                          o_qpc_hdr_lookup_ready,
  input  logic [QP_PTR_WIDTH-1:0]       i_qpc_hdr_lookup_qp_id,
  output logic                          o_qpc_valid,
  output logic [IB_PKEY_WIDTH-1:0]      o_qpc_pkey,
  output logic [IB_PMTU_CODE_WIDTH-1:0] o_qpc_pmtu,
  output logic [IB_QP_WIDTH-1:0]        o_qpc_dest_qpid,
  output logic [IB_PSN_WIDTH-1:0]       o_qpc_sq_curr_psn,
  output logic [IB_MSN_WIDTH-1:0]       o_qpc_sq_curr_msn,
  output logic [IPV6_WIDTH-1:0]         o_qpc_dest_ip,
  output logic [IP_TTL_WIDTH-1:0]       o_qpc_ttl,
  output logic [IP_DSCP_WDITH-1:0]      o_qpc_dscp,
  output logic [ETH_MAC_WIDTH-1:0]      o_qpc_dest_mac,
  input  logic                          i_qpc_hdr_update_valid,
  input  logic [QP_PTR_WIDTH-1:0]       i_qpc_hdr_update_qpid,
  input  logic [IB_PSN_WIDTH-1:0]       i_qpc_sq_curr_psn,
  input  logic [IB_MSN_WIDTH-1:0]       i_qpc_sq_curr_msn,
  output logic [MAX_QP-1:0]             o_lock_vec
);

  logic [IB_PKEY_WIDTH-1:0]      pkey_mem  [MAX_QP];
  logic [IB_PMTU_CODE_WIDTH-1:0] pmtu_mem  [MAX_QP];
  logic [IB_QP_WIDTH-1:0]        dqpn_mem  [MAX_QP];
  logic [IPV6_WIDTH-1:0]         dip_mem   [MAX_QP];
  logic [IP_TTL_WIDTH-1:0]       ttl_mem   [MAX_QP];
  logic [IP_DSCP_WDITH-1:0]      dscp_mem  [MAX_QP];
  logic [ETH_MAC_WIDTH-1:0]      dmac_mem  [MAX_QP];
  logic [IB_PSN_WIDTH-1:0]       psn_mem   [MAX_QP];
  logic [IB_MSN_WIDTH-1:0]       msn_mem   [MAX_QP];
  logic [MAX_QP-1:0]             lock_q;
  logic [MAX_QP-1:0]             lock_d;
  logic                          upd_hit;
  logic                          accept;

  // A write-back in the same cycle releases the lock and supplies fresh PSN/MSN.
  assign upd_hit = i_qpc_hdr_update_valid && (i_qpc_hdr_update_qpid == i_qpc_hdr_lookup_qp_id);
  assign o_qpc_hdr_lookup_ready = !lock_q[i_qpc_hdr_lookup_qp_id] || upd_hit;
  assign accept = i_qpc_hdr_lookup_valid && o_qpc_hdr_lookup_ready;
  assign o_lock_vec = lock_q;

  always_comb begin
    lock_d = lock_q;
    if (i_qpc_hdr_update_valid) lock_d[i_qpc_hdr_update_qpid] = 1'b0;
    if (accept) lock_d[i_qpc_hdr_lookup_qp_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= '0;
    end else begin
      lock_q <= lock_d;
    end
  end

  // Config is written after the update so it wins PSN/MSN on a same-QP collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_QP; i++) begin
        pkey_mem[i] <= '0;
        pmtu_mem[i] <= '0;
        dqpn_mem[i] <= '0;
        dip_mem[i]  <= '0;
        ttl_mem[i]  <= '0;
        dscp_mem[i] <= '0;
        dmac_mem[i] <= '0;
        psn_mem[i]  <= '0;
        msn_mem[i]  <= '0;
      end
    end else begin
      if (i_qpc_hdr_update_valid) begin
        psn_mem[i_qpc_hdr_update_qpid] <= i_qpc_sq_curr_psn;
        msn_mem[i_qpc_hdr_update_qpid] <= i_qpc_sq_curr_msn;
      end
      if (i_cfg_wr_en) begin
        pkey_mem[i_cfg_qpid] <= i_cfg_pkey;
        pmtu_mem[i_cfg_qpid] <= i_cfg_pmtu;
        dqpn_mem[i_cfg_qpid] <= i_cfg_dest_qpid;
        dip_mem[i_cfg_qpid]  <= i_cfg_dest_ip;
        ttl_mem[i_cfg_qpid]  <= i_cfg_ttl;
        dscp_mem[i_cfg_qpid] <= i_cfg_dscp;
        dmac_mem[i_cfg_qpid] <= i_cfg_dest_mac;
        psn_mem[i_cfg_qpid]  <= i_cfg_init_psn;
        msn_mem[i_cfg_qpid]  <= i_cfg_init_msn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_qpc_valid       <= 1'b0;
      o_qpc_pkey        <= '0;
      o_qpc_pmtu        <= '0;
      o_qpc_dest_qpid   <= '0;
      o_qpc_sq_curr_psn <= '0;
      o_qpc_sq_curr_msn <= '0;
      o_qpc_dest_ip     <= '0;
      o_qpc_ttl         <= '0;
      o_qpc_dscp        <= '0;
      o_qpc_dest_mac    <= '0;
    end else begin
      o_qpc_valid <= accept;
      if (accept) begin
        o_qpc_pkey      <= pkey_mem[i_qpc_hdr_lookup_qp_id];
        o_qpc_pmtu      <= pmtu_mem[i_qpc_hdr_lookup_qp_id];
        o_qpc_dest_qpid <= dqpn_mem[i_qpc_hdr_lookup_qp_id];
        o_qpc_dest_ip   <= dip_mem[i_qpc_hdr_lookup_qp_id];
        o_qpc_ttl       <= ttl_mem[i_qpc_hdr_lookup_qp_id];
        o_qpc_dscp      <= dscp_mem[i_qpc_hdr_lookup_qp_id];
        o_qpc_dest_mac  <= dmac_mem[i_qpc_hdr_lookup_qp_id];
        o_qpc_sq_curr_psn <= upd_hit ? i_qpc_sq_curr_psn : psn_mem[i_qpc_hdr_lookup_qp_id];
        o_qpc_sq_curr_msn <= upd_hit ? i_qpc_sq_curr_msn : msn_mem[i_qpc_hdr_lookup_qp_id];
      end
    end
  end

endmodule
